// File: rtl/sleepy_pkg.sv
// Shared constants and types for the sleepy audio path.
package sleepy_pkg;
    localparam int SLEEPY_DATA_W     = 8;
    localparam int SLEEPY_FIFO_DEPTH = 4;

    typedef logic [SLEEPY_DATA_W-1:0] sample_t;
endpackage

// File: rtl/sleepy_sample_fifo.sv
// Synchronous sample FIFO with a registered head; dout is valid whenever !empty.
module sleepy_sample_fifo
    import sleepy_pkg::*;
#(
    parameter int W     = SLEEPY_DATA_W,
    parameter int DEPTH = SLEEPY_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW + 1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = head_q;
    assign level   = level_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path can leave it unassigned (no latches).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Head tracks the oldest entry as it will be after this edge.
        if (do_pop) begin
            if (level_q > ONE_L) head_d = mem_q[rd_ptr_q + 1'b1];
            else if (do_push)    head_d = din;
        end else if (empty && do_push) begin
            head_d = din;
        end
    end

    // NOTE: the storage array is never reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end
endmodule

// File: rtl/sleepy_pwm_out.sv
// PWM audio output stage: sample FIFO feeding a free-running carrier that loads one
// duty value per period and flags underruns.
module sleepy_pwm_out
    import sleepy_pkg::*;
#(
    parameter int DATA_W     = SLEEPY_DATA_W,
    parameter int FIFO_DEPTH = SLEEPY_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clr_underrun,
    output logic                          pwm_out,
    output logic                          frame_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] duty_q, duty_d;
    logic [DATA_W-1:0] fifo_head;
    logic              pwm_q, pwm_d;
    logic              tick_q, tick_d;
    logic              underrun_q, underrun_d;
    logic              fifo_full, fifo_empty;
    logic              push, load, pop;

    assign s_ready = ~fifo_full;
    assign push    = s_valid & s_ready;
    assign load    = ena & (cnt_q == '1);
    // Empty is sampled from registered state, so a same-cycle push never feeds a load.
    assign pop     = load & ~fifo_empty;

    sleepy_sample_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (fifo_head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cnt_d      = ena ? cnt_q + 1'b1 : cnt_q;
        duty_d     = pop ? fifo_head : duty_q;
        pwm_d      = ena & (cnt_q < duty_q);
        tick_d     = load;
        underrun_d = underrun_q;
        if (clr_underrun)       underrun_d = 1'b0;
        if (load && fifo_empty) underrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_tick = tick_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_sleepy_pwm_out.sv
// Self-checking bench for sleepy_pwm_out: queue-based reference model, duty table,
// directed corner sequences and randomized traffic.
module tb_sleepy_pwm_out;
    import sleepy_pkg::*;

    localparam int PERIOD = 256;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst, ena, s_valid, clr_underrun;
    sample_t    s_data;
    logic       s_ready, pwm_out, frame_tick, underrun;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    // Reference model state: sample queue, counter phase, current duty, registered outputs.
    int m_q[$];
    int m_cnt, m_duty;
    bit m_pwm, m_tick, m_ur, m_pushed;

    typedef struct {
        sample_t duty;
        int      high;
    } duty_vec_t;

    duty_vec_t vecs[6];

    sleepy_pwm_out dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .clr_underrun (clr_underrun),
        .pwm_out      (pwm_out),
        .frame_tick   (frame_tick),
        .underrun     (underrun),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit ld, set_ur;
        if (rst) begin
            m_q.delete();
            m_cnt = 0; m_duty = 0;
            m_pwm = 0; m_tick = 0; m_ur = 0; m_pushed = 0;
            return;
        end
        m_pushed = s_valid && (m_q.size() < DEPTH);
        ld       = ena && (m_cnt == PERIOD - 1);
        set_ur   = 0;
        m_pwm    = ena && (m_cnt < m_duty);
        m_tick   = ld;
        if (ld) begin
            if (m_q.size() > 0) m_duty = m_q.pop_front();
            else                set_ur = 1;
        end
        if (set_ur)            m_ur = 1;
        else if (clr_underrun) m_ur = 0;
        if (m_pushed) m_q.push_back(int'(s_data));
        if (ena) m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    task automatic cycle();
        logic [6:0] exp_v;
        model_step();
        @(posedge clk);
        #1;
        exp_v = {m_pwm, m_tick, m_ur, m_q.size() != DEPTH, 3'(m_q.size())};
        check("outputs{pwm,tick,ur,ready,level}",
              {25'd0, pwm_out, frame_tick, underrun, s_ready, level}, {25'd0, exp_v});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push_one(input sample_t d);
        s_valid = 1'b1;
        s_data  = d;
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!frame_tick && n < budget);
        check("tick_seen", frame_tick, 1);
    endtask

    task automatic run_to_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 2 * PERIOD) begin
            cycle();
            n++;
        end
    endtask

    // Counts high pwm clocks over the 256 clocks following a frame_tick.
    task automatic measure(output int high);
        high = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cycle();
            high += int'(pwm_out);
        end
        check("period_end_tick", frame_tick, 1);
    endtask

    initial begin
        int n, high;

        vecs[0] = '{8'h80, 128};
        vecs[1] = '{8'h00, 0};
        vecs[2] = '{8'hFF, 255};
        vecs[3] = '{8'h01, 1};
        vecs[4] = '{8'h40, 64};
        vecs[5] = '{8'hC3, 195};

        rst = 1'b1; ena = 1'b0; s_valid = 1'b0; s_data = '0; clr_underrun = 1'b0;

        // Reset values
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_pwm", pwm_out, 0);
        check("rst_ready", s_ready, 1);
        check("rst_level", level, 0);
        check("rst_underrun", underrun, 0);
        check("rst_tick", frame_tick, 0);
        ena = 1'b1;

        // Full FIFO with a held fifth sample
        for (int i = 0; i < DEPTH; i++) push_one(sample_t'(8'h10 + i));
        check("full_level", level, 4);
        check("full_ready", s_ready, 0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        wait_tick(300, n);
        check("after_load_level", level, 3);
        check("after_load_ready", s_ready, 1);
        cycle();
        s_valid = 1'b0;
        check("fifth_accepted_level", level, 4);

        // Duty table, one sample per period
        do_reset();
        ena = 1'b1;
        wait_tick(300, n);
        foreach (vecs[i]) begin
            push_one(vecs[i].duty);
            wait_tick(300, n);
            check("tick_spacing", n, PERIOD - 1);
            measure(high);
            check($sformatf("duty_%02h_high", vecs[i].duty), high, vecs[i].high);
        end

        // Underrun: repeat duty, clear, set-wins-over-clear
        do_reset();
        ena = 1'b1;
        push_one(8'h30);
        wait_tick(300, n);
        measure(high);
        check("first_period_high", high, 8'h30);
        check("underrun_set", underrun, 1);
        measure(high);
        check("repeat_duty_high", high, 8'h30);
        clr_underrun = 1'b1;
        cycle();
        clr_underrun = 1'b0;
        check("underrun_cleared", underrun, 0);
        run_to_cnt(PERIOD - 1);
        clr_underrun = 1'b1;
        cycle();
        clr_underrun = 1'b0;
        check("underrun_set_wins", underrun, 1);

        // ena freeze mid-period, then reset mid-period
        do_reset();
        ena = 1'b1;
        push_one(8'h80);
        wait_tick(300, n);
        run_to_cnt(8'h40);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("frozen_pwm", pwm_out, 0);
        end
        ena = 1'b1;
        wait_tick(300, n);
        check("resume_from_40", n, PERIOD - 8'h40);
        run_to_cnt(8'h90);
        push_one(8'h11);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_pwm", pwm_out, 0);
        check("midrst_level", level, 0);
        check("midrst_ready", s_ready, 1);
        check("midrst_underrun", underrun, 0);
        check("midrst_tick", frame_tick, 0);

        // Randomized traffic: sparse producer, then dense producer
        for (int i = 0; i < 6000; i++) begin
            int rate = (i < 3000) ? 300 : 2;
            rst          = ($urandom_range(0, 799) == 0);
            ena          = ($urandom_range(0, 9) != 0);
            clr_underrun = ($urandom_range(0, 49) == 0);
            if (!s_valid || m_pushed) begin
                s_valid = ($urandom_range(0, rate - 1) == 0);
                s_data  = sample_t'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
